// File: rtl/vertical_vga.sv
// vertical_vga: vertical VGA timing FSM producing VSYNC, scaled VRAM row address, v_active and frame_done.
module vertical_vga #(
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_DISP = 480,
  parameter int SCALE  = 5,
  parameter int ROWS   = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_done,
  output logic       VSYNC,
  output logic [6:0] VPIXEL,
  output logic       v_active,
  output logic       frame_done
);
  typedef enum logic [1:0] {FRONT_PORCH, SYNC, BACK_PORCH, DISPLAY} state_t;
  state_t     state, state_nx;
  logic [9:0] cnt, cnt_nx, len;
  logic [2:0] sub, sub_nx;
  logic [6:0] vpix_nx;
  logic       last, wrap, disp_run, fd_nx;
  always_comb begin
    len = state == FRONT_PORCH ? 10'(V_FP) :
          state == SYNC        ? 10'(V_SYNC) :
          state == BACK_PORCH  ? 10'(V_BP) : 10'(V_DISP);
    last = cnt == len - 10'd1;
    wrap = sub == 3'(SCALE - 1);
    disp_run = state == DISPLAY && !last;
    state_nx = state;
    cnt_nx = cnt;
    sub_nx = sub;
    vpix_nx = VPIXEL;
    fd_nx = 1'b0;
    if (line_done) begin
      state_nx = !last ? state :
                 state == FRONT_PORCH ? SYNC :
                 state == SYNC ? BACK_PORCH :
                 state == BACK_PORCH ? DISPLAY : FRONT_PORCH;
      cnt_nx = last ? 10'd0 : cnt + 10'd1;
      // Row/sub counters only run inside the visible region and snap to 0 on frame wrap
      sub_nx = !disp_run ? 3'd0 : wrap ? 3'd0 : sub + 3'd1;
      vpix_nx = !disp_run ? 7'd0 :
                !wrap ? VPIXEL :
                VPIXEL == 7'(ROWS - 1) ? 7'd0 : VPIXEL + 7'd1;
      fd_nx = state == DISPLAY && last;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FRONT_PORCH;
      cnt <= '0;
      sub <= '0;
      VPIXEL <= '0;
      VSYNC <= 1'b1;
      v_active <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      sub <= sub_nx;
      VPIXEL <= vpix_nx;
      VSYNC <= state_nx != SYNC;
      v_active <= state_nx == DISPLAY;
      frame_done <= fd_nx;
    end
endmodule
